// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   dmem_state_t  : responder FSM states (IDLE, WAIT, RESP)
//   BE_WORD       : byte-enable pattern of a full-word access
//   be_contiguous : 1 when the set byte lanes form one unbroken run
//                   (an empty mask counts as contiguous)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic be_contiguous(input logic [3:0] be);
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110,
            4'b1111: be_contiguous = 1'b1;
            default: be_contiguous = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with per-byte write enables.
// Write is synchronous (rising clk), read is asynchronous.
// Contents have no reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write strobe for this cycle
//   be_i     in   4 byte-lane enables for the write
//   waddr_i  in   word index for the write
//   wdata_i  in   write data, lanes aligned to the word
//   raddr_i  in   word index for the read
//   rdata_o  out  word currently stored at raddr_i
module dmem_ram #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory-stage load/store port.
// A request is accepted in IDLE or RESP (cycle 0), waits LATENCY-1 cycles
// and completes in cycle LATENCY (RESP) with a one-cycle RspValidM pulse.
// Stores commit to the RAM at the end of RESP; loads present the RAM word
// of the RESP cycle on ReadDataM, which then holds until the next load.
// Handshake: MemReqM is sampled only outside WAIT; while StallM is high
// the requester keeps its inputs stable, and anything on the inputs
// during WAIT is ignored.
// Optional feature: define DMEM_ERR_EN to flag misaligned requests on ErrM.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   MemReqM     in   request valid
//   MemWriteM   in   1 = store, 0 = load
//   ALUResultM  in   byte address (word index in bits [IDX_W+1:2])
//   WriteDataM  in   store data
//   ByteEnM     in   store byte-lane enables
//   ReadDataM   out  registered load data
//   RspValidM   out  registered completion pulse
//   StallM      out  transaction open (combinational from MemReqM)
//   ErrM        out  registered error flag (0 without DMEM_ERR_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteEnM,
    output logic [31:0] ReadDataM,
    output logic        RspValidM,
    output logic        StallM,
    output logic        ErrM
);

    localparam int                IDX_W       = $clog2(DEPTH_WORDS);
    localparam int                CNT_W       = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_START   = CNT_W'(LATENCY - 1);
    localparam logic              MULTI_CYCLE = (LATENCY > 1);

    dmem_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [31:0]      rdata_q;
    logic             rsp_valid_q;

    logic [IDX_W-1:0] req_idx;
    logic             accept;
    logic             resp_from_wait;
    logic             enter_resp;
    logic             rsp_we;
    logic [IDX_W-1:0] rsp_idx;
    logic             rsp_err;
    logic             commit_ok;
    logic             commit;
    logic [31:0]      ram_rdata;
    logic [31:0]      rd_word;
    logic [31:0]      rdata_d;

    // Upper address bits alias onto the RAM; the byte offset only matters
    // for error detection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ALUResultM[31:IDX_W+2], ALUResultM[1:0]};

    assign req_idx        = ALUResultM[IDX_W+1:2];
    assign accept         = MemReqM && (state_q != WAIT);
    assign resp_from_wait = (state_q == WAIT) && (cnt_q == CNT_W'(1));
    // With LATENCY=1 an accepted request goes straight to RESP.
    assign enter_resp     = resp_from_wait || (accept && !MULTI_CYCLE);

    // Attributes of the transaction that is about to enter RESP: either the
    // latched one leaving WAIT or, for LATENCY=1, the one on the inputs.
    assign rsp_we  = resp_from_wait ? we_q  : MemWriteM;
    assign rsp_idx = resp_from_wait ? idx_q : req_idx;

`ifdef DMEM_ERR_EN
    logic req_err;
    logic err_q;
    logic err_out_q;

    // Full-word accesses (loads, word stores) need a word-aligned address;
    // partial stores need an unbroken run of byte lanes.
    assign req_err = (MemWriteM && !be_contiguous(ByteEnM)) ||
                     ((ALUResultM[1:0] != 2'b00) && (!MemWriteM || (ByteEnM == BE_WORD)));
    assign rsp_err   = resp_from_wait ? err_q : req_err;
    assign commit_ok = !err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= req_err;
            end
            err_out_q <= enter_resp && rsp_err;
        end
    end

    assign ErrM = err_out_q;
`else
    assign rsp_err   = 1'b0;
    assign commit_ok = 1'b1;
    assign ErrM      = 1'b0;
`endif

    assign commit = (state_q == RESP) && we_q && commit_ok;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (commit),
        .be_i    (be_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rsp_idx),
        .rdata_o (ram_rdata)
    );

    // A load entering RESP on the same edge a store commits (LATENCY=1,
    // back-to-back) must see the store's bytes, so forward them here.
    always_comb begin
        rd_word = ram_rdata;
        if (commit && (idx_q == rsp_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    rd_word[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign rdata_d = rsp_err ? 32'h0 : rd_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= enter_resp;
            if (enter_resp && !rsp_we) begin
                rdata_q <= rdata_d;
            end

            case (state_q)
                IDLE, RESP: begin
                    if (MemReqM) begin
                        idx_q   <= req_idx;
                        wdata_q <= WriteDataM;
                        be_q    <= ByteEnM;
                        we_q    <= MemWriteM;
                        if (MULTI_CYCLE) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_START;
                        end else begin
                            state_q <= RESP;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReadDataM = rdata_q;
    assign RspValidM = rsp_valid_q;
    assign StallM    = (state_q == WAIT) || (MemReqM && (state_q != WAIT) && MULTI_CYCLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder (DEPTH_WORDS=64, LATENCY=2).
// Reference model: a plain word array updated byte-lane by byte-lane when
// a store completes, and a queue of expected load words.
module tb_dmem_responder;

    localparam int D = 64;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemReqM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [3:0]  ByteEnM = '0;
    logic [31:0] ReadDataM;
    logic        RspValidM;
    logic        StallM;
    logic        ErrM;

    dmem_responder #(
        .DEPTH_WORDS(D),
        .LATENCY(L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ByteEnM    (ByteEnM),
        .ReadDataM  (ReadDataM),
        .RspValidM  (RspValidM),
        .StallM     (StallM),
        .ErrM       (ErrM)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] mem_m [D];
    logic [31:0] last_rd = '0;
    logic [31:0] exp_q [$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % D);
    endfunction

    function automatic bit lanes_contig(input logic [3:0] be);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) return 1'b1;
        for (int i = lo; i <= hi; i++) begin
            if (!be[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_err(input logic we, input logic [31:0] addr, input logic [3:0] be);
`ifdef DMEM_ERR_EN
        if ((addr[1:0] != 2'b00) && (!we || be == 4'hF)) return 1'b1;
        if (we && !lanes_contig(be)) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int k;
        k = idx_of(addr);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[k][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one request in the current cycle and follows it to its RESP
    // cycle, checking StallM/RspValidM/ErrM/ReadDataM on the way. During WAIT
    // the inputs are scrambled (they must be ignored). With hold=1 the task
    // returns inside the RESP cycle so the caller can issue back-to-back.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input bit hold, output int rsp_cyc);
        bit e;
        e = model_err(we, addr, be);
        MemReqM    = 1'b1;
        MemWriteM  = we;
        ALUResultM = addr;
        WriteDataM = wd;
        ByteEnM    = be;
        if (!we) exp_q.push_back(e ? 32'h0 : mem_m[idx_of(addr)]);
        #1;
        chk("stall_c0", StallM, (L > 1) ? 32'd1 : 32'd0);
        for (int k = 1; k < L; k++) begin
            @(negedge clk);
            MemReqM    = 1'($urandom_range(0, 1));
            MemWriteM  = 1'($urandom_range(0, 1));
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            ByteEnM    = 4'($urandom_range(0, 15));
            #1;
            chk("stall_wait", StallM, 32'd1);
            chk("rsp_wait", RspValidM, 32'd0);
        end
        @(negedge clk);
        if (!hold) MemReqM = 1'b0;
        #1;
        chk("rsp_valid", RspValidM, 32'd1);
        chk("rsp_err", ErrM, e);
        if (!we) last_rd = exp_q.pop_front();
        chk(we ? "rdata_hold" : "rdata_load", ReadDataM, last_rd);
        if (we && !e) model_store(addr, wd, be);
        rsp_cyc = cyc;
        if (!hold) begin
            chk("stall_resp", StallM, 32'd0);
            @(negedge clk);
            #1;
            chk("rsp_idle", RspValidM, 32'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int c1;
        int c2;
        logic [31:0] old_w;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_rsp", RspValidM, 32'd0);
        chk("rst_stall", StallM, 32'd0);
        chk("rst_err", ErrM, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // give every RAM word a known value
        for (int i = 0; i < D; i++) begin
            run_txn(1'b1, 32'(i * 4), $urandom, 4'hF, bit'($urandom_range(0, 1)), c1);
        end
        if (c1 == 0) @(negedge clk);
        MemReqM = 1'b0;
        @(negedge clk);

        // 1: word store then load
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, c1);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, c1);
        chk("t1_load", ReadDataM, 32'hDEADBEEF);

        // 2: single byte-lane store
        run_txn(1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b0, c1);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, c1);
        chk("t2_byte", ReadDataM, 32'hDEAABEEF);

        // 3: back-to-back read-after-write
        run_txn(1'b1, 32'h20, 32'h00000011, 4'hF, 1'b1, c1);
        run_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, c2);
        chk("t3_raw", ReadDataM, 32'h00000011);
        chk("t3_gap", 32'(c2 - c1), 32'(L));

        // 4: reset during WAIT abandons the store
        old_w      = mem_m[idx_of(32'h30)];
        MemReqM    = 1'b1;
        MemWriteM  = 1'b1;
        ALUResultM = 32'h30;
        WriteDataM = 32'h5;
        ByteEnM    = 4'hF;
        @(negedge clk);
        #1;
        chk("t4_in_wait", StallM, 32'd1);
        reset   = 1'b1;
        MemReqM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4_rdata", ReadDataM, 32'h0);
        chk("t4_rsp", RspValidM, 32'd0);
        chk("t4_stall", StallM, 32'd0);
        chk("t4_err", ErrM, 32'd0);
        last_rd = 32'h0;
        @(negedge clk);
        #1;
        chk("t4_no_rsp", RspValidM, 32'd0);
        run_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, c1);
        chk("t4_old", ReadDataM, old_w);

        // 5: address wrap
        run_txn(1'b1, 32'h100, 32'h7, 4'hF, 1'b0, c1);
        run_txn(1'b0, 32'h000, 32'h0, 4'h0, 1'b0, c1);
        chk("t5_wrap", ReadDataM, 32'h7);

`ifdef DMEM_ERR_EN
        // 6: misaligned word store is flagged and dropped
        old_w = mem_m[idx_of(32'h10)];
        run_txn(1'b1, 32'h13, 32'h12345678, 4'hF, 1'b0, c1);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, c1);
        chk("t6_unchanged", ReadDataM, old_w);
`endif

        // random traffic
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), c1);
        end
        MemReqM = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
